// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Control FSM for a multi-cycle MIPS-style datapath. It sequences each
// instruction through FETCH / DECODE / execute / writeback states and drives
// the datapath mux selects, the memory strobes and the register-file write
// enable. It also counts retired instructions and watches memory handshakes
// for a stall that never ends.
//
// Parameters
//   MEM_WAIT_MAX  number of consecutive mem_ready=0 cycles tolerated in one
//                 memory state (FETCH, MEMRD, MEMWR) before giving up (>= 1)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; forces every output to 0
//   opcode       IR[31:26], stable from DECODE onward
//   funct        IR[5:0]; not used here, the ALU decodes it when alu_op=10
//   zero         ALU zero flag, used by beq/bne
//   mem_ready    memory completes the current access this cycle
//   pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]
//                datapath controls, combinational from state and inputs
//   instr_done   one-cycle pulse in the last cycle of each instruction
//   illegal_op   one-cycle pulse in DECODE for an unsupported opcode
//   mem_timeout  sticky flag, set when a memory stall hits MEM_WAIT_MAX
//   instr_count  retired instruction count, wraps modulo 2^32
//   state        current FSM state (debug)
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // The counter only ever holds 0..MEM_WAIT_MAX-1: the stall that would
    // take it to MEM_WAIT_MAX is the timeout cycle itself.
    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               mem_state;
    logic               wait_hit;
    logic               timeout_q;
    logic [31:0]        count_q;

    // funct is carried only for the ALU decoder; reduce it so it is consumed.
    logic unused_funct;
    assign unused_funct = ^funct;

    // A stall cycle that completes MEM_WAIT_MAX consecutive stalls. If the
    // memory answers in that cycle mem_ready=1 and wait_hit stays low, so the
    // access completes normally.
    always_comb begin
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                    (state_q == S_MEMWR);
        wait_hit  = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    end

    // Next state and control outputs. Reset overrides everything to 0.
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        if (reset) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // PC+4 is computed while the instruction is read; both
                    // the IR and PC only load once the memory delivers.
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target computed speculatively from the offset.
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW:              state_d = S_MEMADR;
                        OP_RTYPE:                  state_d = S_RTEX;
                        OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
                        OP_J:                      state_d = S_JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (wait_hit) begin
                        state_d = S_FETCH;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else if (wait_hit) begin
                        state_d = S_FETCH;
                    end
                end
                S_RTEX: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_RTWB;
                end
                S_RTWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_src     = 2'b01;
                    pc_en      = ((opcode == OP_BEQ) && zero) ||
                                 ((opcode == OP_BNE) && !zero);
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    // addi adds; andi/ori let the ALU pick the logic op.
                    alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
                    state_d   = S_IMMWB;
                end
                S_IMMWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Consecutive-stall counter, restarted whenever the state moves on or a
    // timeout fires (a timeout in FETCH stays in FETCH, so it is explicit).
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (wait_hit || (state_d != state_q)) begin
            wait_cnt <= '0;
        end else if (mem_state && !mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (wait_hit) begin
            timeout_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (instr_done) begin
            count_q <= count_q + 32'd1;
        end
    end

    // Registered outputs are also held at 0 while reset is asserted.
    assign instr_count = reset ? 32'd0 : count_q;
    assign mem_timeout = !reset && timeout_q;
    assign state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//
// Directed bench for multi_cycle_ctrl (MEM_WAIT_MAX=4). Each cycle the state
// and a packed vector of all control outputs are compared against
// hand-written expectations.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        instr_done, illegal_op, mem_timeout;
    logic [31:0] instr_count;
    logic [3:0]  state;

    int checks   = 0;
    int failures = 0;

    multi_cycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout),
        .instr_count(instr_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control outputs, MSB first.
    logic [16:0] ctrl;
    assign ctrl = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_src, instr_done, illegal_op};

    localparam logic [16:0] B_PCEN   = 17'(1) << 16;
    localparam logic [16:0] B_IORD   = 17'(1) << 15;
    localparam logic [16:0] B_MRD    = 17'(1) << 14;
    localparam logic [16:0] B_MWR    = 17'(1) << 13;
    localparam logic [16:0] B_IRW    = 17'(1) << 12;
    localparam logic [16:0] B_RDST   = 17'(1) << 11;
    localparam logic [16:0] B_M2R    = 17'(1) << 10;
    localparam logic [16:0] B_RW     = 17'(1) << 9;
    localparam logic [16:0] B_SRCA   = 17'(1) << 8;
    localparam logic [16:0] B_SRCB01 = 17'(1) << 6;
    localparam logic [16:0] B_SRCB10 = 17'(2) << 6;
    localparam logic [16:0] B_SRCB11 = 17'(3) << 6;
    localparam logic [16:0] B_OP01   = 17'(1) << 4;
    localparam logic [16:0] B_OP10   = 17'(2) << 4;
    localparam logic [16:0] B_OP11   = 17'(3) << 4;
    localparam logic [16:0] B_PCS01  = 17'(1) << 2;
    localparam logic [16:0] B_PCS10  = 17'(2) << 2;
    localparam logic [16:0] B_DONE   = 17'(1) << 1;
    localparam logic [16:0] B_ILL    = 17'(1);

    localparam logic [16:0] E_ZERO   = 17'd0;
    localparam logic [16:0] E_F_RDY  = B_PCEN | B_MRD | B_IRW | B_SRCB01;
    localparam logic [16:0] E_F_WAIT = B_MRD | B_SRCB01;
    localparam logic [16:0] E_DEC    = B_SRCB11;
    localparam logic [16:0] E_DECILL = B_SRCB11 | B_ILL;
    localparam logic [16:0] E_MADR   = B_SRCA | B_SRCB10;
    localparam logic [16:0] E_MRD    = B_MRD | B_IORD;
    localparam logic [16:0] E_MWB    = B_RW | B_M2R | B_DONE;
    localparam logic [16:0] E_MWR_W  = B_MWR | B_IORD;
    localparam logic [16:0] E_MWR_R  = B_MWR | B_IORD | B_DONE;
    localparam logic [16:0] E_RTEX   = B_SRCA | B_OP10;
    localparam logic [16:0] E_RTWB   = B_RW | B_RDST | B_DONE;
    localparam logic [16:0] E_BR_T   = B_PCEN | B_SRCA | B_OP01 | B_PCS01 | B_DONE;
    localparam logic [16:0] E_BR_N   = B_SRCA | B_OP01 | B_PCS01 | B_DONE;
    localparam logic [16:0] E_IMMADD = B_SRCA | B_SRCB10;
    localparam logic [16:0] E_IMMLOG = B_SRCA | B_SRCB10 | B_OP11;
    localparam logic [16:0] E_IMMWB  = B_RW | B_DONE;
    localparam logic [16:0] E_JMP    = B_PCEN | B_PCS10 | B_DONE;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs for this cycle are already driven; settle, compare, advance.
    task automatic cyc(input string tag, input logic [3:0] exp_st,
                       input logic [16:0] exp_ctl);
        #1;
        chk({tag, "/state"}, 32'(state), 32'(exp_st));
        chk({tag, "/ctrl"}, 32'(ctrl), 32'(exp_ctl));
        chk({tag, "/rw_excl"}, 32'(mem_read & mem_write), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Outputs held at 0 while reset is high, even with mem_ready=1.
        chk("rst/ctrl", 32'(ctrl), 32'd0);
        chk("rst/state", 32'(state), 32'd0);
        chk("rst/count", instr_count, 32'd0);
        chk("rst/timeout", 32'(mem_timeout), 32'd0);
        reset = 1'b0;

        // lw, memory ready throughout
        opcode = 6'b100011; mem_ready = 1'b1;
        cyc("lw1", 4'd0, E_F_RDY);
        cyc("lw2", 4'd1, E_DEC);
        cyc("lw3", 4'd2, E_MADR);
        cyc("lw4", 4'd3, E_MRD);
        cyc("lw5", 4'd4, E_MWB);
        chk("lw/count", instr_count, 32'd1);

        // beq taken
        opcode = 6'b000100; zero = 1'b1;
        cyc("beq1", 4'd0, E_F_RDY);
        cyc("beq2", 4'd1, E_DEC);
        cyc("beq3", 4'd8, E_BR_T);

        // bne with zero=1: not taken, still retires
        opcode = 6'b000101; zero = 1'b1;
        cyc("bne1", 4'd0, E_F_RDY);
        cyc("bne2", 4'd1, E_DEC);
        cyc("bne3", 4'd8, E_BR_N);
        chk("br/count", instr_count, 32'd3);
        zero = 1'b0;

        // R-type with three FETCH stall cycles
        opcode = 6'b000000; mem_ready = 1'b0;
        cyc("rt_w1", 4'd0, E_F_WAIT);
        cyc("rt_w2", 4'd0, E_F_WAIT);
        cyc("rt_w3", 4'd0, E_F_WAIT);
        mem_ready = 1'b1;
        cyc("rt_f", 4'd0, E_F_RDY);
        cyc("rt_d", 4'd1, E_DEC);
        cyc("rt_ex", 4'd6, E_RTEX);
        cyc("rt_wb", 4'd7, E_RTWB);
        chk("rt/count", instr_count, 32'd4);
        chk("rt/timeout", 32'(mem_timeout), 32'd0);

        // addi and ori
        opcode = 6'b001000;
        cyc("addi1", 4'd0, E_F_RDY);
        cyc("addi2", 4'd1, E_DEC);
        cyc("addi3", 4'd9, E_IMMADD);
        cyc("addi4", 4'd10, E_IMMWB);
        opcode = 6'b001101;
        cyc("ori1", 4'd0, E_F_RDY);
        cyc("ori2", 4'd1, E_DEC);
        cyc("ori3", 4'd9, E_IMMLOG);
        cyc("ori4", 4'd10, E_IMMWB);

        // j
        opcode = 6'b000010;
        cyc("j1", 4'd0, E_F_RDY);
        cyc("j2", 4'd1, E_DEC);
        cyc("j3", 4'd11, E_JMP);
        chk("j/count", instr_count, 32'd7);

        // sw with two write stall cycles
        opcode = 6'b101011;
        cyc("sw1", 4'd0, E_F_RDY);
        cyc("sw2", 4'd1, E_DEC);
        cyc("sw3", 4'd2, E_MADR);
        mem_ready = 1'b0;
        cyc("sw_w1", 4'd5, E_MWR_W);
        cyc("sw_w2", 4'd5, E_MWR_W);
        mem_ready = 1'b1;
        cyc("sw_r", 4'd5, E_MWR_R);
        chk("sw/count", instr_count, 32'd8);

        // illegal opcode: no retire
        opcode = 6'b111111;
        cyc("ill1", 4'd0, E_F_RDY);
        cyc("ill2", 4'd1, E_DECILL);
        chk("ill/next_state", 32'(state), 32'd0);
        chk("ill/count", instr_count, 32'd8);

        // lw answered on the last tolerated cycle: completes, no timeout
        opcode = 6'b100011;
        cyc("lwb1", 4'd0, E_F_RDY);
        cyc("lwb2", 4'd1, E_DEC);
        cyc("lwb3", 4'd2, E_MADR);
        mem_ready = 1'b0;
        cyc("lwb_w1", 4'd3, E_MRD);
        cyc("lwb_w2", 4'd3, E_MRD);
        cyc("lwb_w3", 4'd3, E_MRD);
        mem_ready = 1'b1;
        cyc("lwb_r", 4'd3, E_MRD);
        cyc("lwb_wb", 4'd4, E_MWB);
        chk("lwb/count", instr_count, 32'd9);
        chk("lwb/timeout", 32'(mem_timeout), 32'd0);

        // lw with memory stuck: timeout after four stall cycles
        cyc("lwt1", 4'd0, E_F_RDY);
        cyc("lwt2", 4'd1, E_DEC);
        cyc("lwt3", 4'd2, E_MADR);
        mem_ready = 1'b0;
        cyc("lwt_w1", 4'd3, E_MRD);
        cyc("lwt_w2", 4'd3, E_MRD);
        cyc("lwt_w3", 4'd3, E_MRD);
        cyc("lwt_w4", 4'd3, E_MRD);
        chk("lwt/timeout", 32'(mem_timeout), 32'd1);
        chk("lwt/state", 32'(state), 32'd0);
        chk("lwt/count", instr_count, 32'd9);

        // Stall counter restarted: three FETCH stalls do not time out again
        opcode = 6'b000010;
        cyc("ft_w1", 4'd0, E_F_WAIT);
        cyc("ft_w2", 4'd0, E_F_WAIT);
        cyc("ft_w3", 4'd0, E_F_WAIT);
        mem_ready = 1'b1;
        cyc("ft_f", 4'd0, E_F_RDY);
        cyc("ft_d", 4'd1, E_DEC);
        cyc("ft_j", 4'd11, E_JMP);
        chk("ft/count", instr_count, 32'd10);
        chk("ft/timeout_sticky", 32'(mem_timeout), 32'd1);

        // reset in the middle of a sw write
        opcode = 6'b101011;
        cyc("swr1", 4'd0, E_F_RDY);
        cyc("swr2", 4'd1, E_DEC);
        cyc("swr3", 4'd2, E_MADR);
        mem_ready = 1'b0;
        cyc("swr_w", 4'd5, E_MWR_W);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("swr_rst/count_out", instr_count, 32'd0);
        chk("swr_rst/timeout_out", 32'(mem_timeout), 32'd0);
        cyc("swr_rst", 4'd0, E_ZERO);
        reset = 1'b0;
        chk("post_rst/count", instr_count, 32'd0);
        chk("post_rst/timeout", 32'(mem_timeout), 32'd0);
        cyc("post_rst_f", 4'd0, E_F_RDY);
        chk("post_rst/state", 32'(state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
